mac_operand_loader: RTL and testbench

- Upstream feeder for the registered multiply-add stage (DATA_OUT <= A*B + C on every clk edge).
- Accepts a byte-serial operand stream with a valid/ready handshake and assembles ordered triplets A, B, C.
- Presents each complete triplet on stable parallel buses with a one-cycle strobe.
- Emits res_valid aligned to the cycle in which the multiply-add stage's DATA_OUT carries that triplet's result.

---
 rtl/mac_operand_loader.sv | 161 ++++++++++++++++
 tb/tb_mac_operand_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_loader.sv
// mac_operand_loader
// Byte-serial front end for the registered multiply-add stage. Collects
// ordered A, B, C words, presents each complete triplet on stable parallel
// buses with a one-cycle op_strobe, and raises res_valid in the cycle the
// multiply-add stage's DATA_OUT holds that triplet's result.
//
// Optional build: define MAC_LOADER_TRIPLET_CNT_EN to add a wrapping
// triplet counter (triplet_cnt) and a saturating resync counter (err_cnt).
//
// Handshake: a word transfers on a rising clk edge where in_valid && in_ready.
// in_ready is 1 while collecting A or B; while waiting for C it follows !stall,
// so a stalled downstream holds the last word (and any resync word) upstream.
// in_ready never depends on in_valid.
module mac_operand_loader #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_first,
  output logic                  in_ready,
  input  logic                  stall,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  output logic [DATA_WIDTH-1:0] C,
  output logic                  op_strobe,
  output logic                  res_valid,
  output logic                  sync_err
`ifdef MAC_LOADER_TRIPLET_CNT_EN
  ,
  output logic [15:0]           triplet_cnt,
  output logic [7:0]            err_cnt
`endif
);

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    WAIT_C = 2'd2
  } state_t;

  // state_q is the single source of FSM state; checkers bind to it directly.
  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] shadow_a;
  logic [DATA_WIDTH-1:0] shadow_b;
  logic                  accept;
  logic                  load_a;
  logic                  load_b;
  logic                  fire;
  logic                  resync;

  // Ready is withheld only while the C word would launch a new triplet.
  always_comb begin
    in_ready = 1'b1;
    if (state_q == WAIT_C) in_ready = !stall;
  end

  assign accept = in_valid && in_ready;

  // Next-state and datapath controls; in_first restarts a frame from B or C.
  always_comb begin
    state_d = state_q;
    load_a  = 1'b0;
    load_b  = 1'b0;
    fire    = 1'b0;
    resync  = 1'b0;
    case (state_q)
      WAIT_A: begin
        if (accept) begin
          load_a  = 1'b1;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (accept) begin
          if (in_first) begin
            load_a  = 1'b1;
            resync  = 1'b1;
            state_d = WAIT_B;
          end else begin
            load_b  = 1'b1;
            state_d = WAIT_C;
          end
        end
      end
      WAIT_C: begin
        if (accept) begin
          if (in_first) begin
            load_a  = 1'b1;
            resync  = 1'b1;
            state_d = WAIT_B;
          end else begin
            fire    = 1'b1;
            state_d = WAIT_A;
          end
        end
      end
      default: state_d = WAIT_A;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_A;
    else        state_q <= state_d;
  end

  // Shadow operands collect A and B until C completes the triplet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_a <= '0;
      shadow_b <= '0;
    end else begin
      if (load_a) shadow_a <= in_data;
      if (load_b) shadow_b <= in_data;
    end
  end

  // Output operands move only when a triplet fires, so the multiply-add
  // stage keeps recomputing the same result between triplets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A <= '0;
      B <= '0;
      C <= '0;
    end else if (fire) begin
      A <= shadow_a;
      B <= shadow_b;
      C <= in_data;
    end
  end

  // Pulses: res_valid trails op_strobe by the multiply-add register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_strobe <= 1'b0;
      res_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      op_strobe <= fire;
      res_valid <= op_strobe;
      sync_err  <= resync;
    end
  end

`ifdef MAC_LOADER_TRIPLET_CNT_EN
  // Triplet count wraps; resync count saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      triplet_cnt <= '0;
      err_cnt     <= '0;
    end else begin
      if (fire) triplet_cnt <= triplet_cnt + 16'd1;
      if (resync && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_operand_loader.sv
// tb_mac_operand_loader
// Drives word streams into mac_operand_loader and compares every cycle with a
// queue-based frame model. A behavioural multiply-add register stands in for
// the downstream stage so res_valid alignment can be checked against results.
module tb_mac_operand_loader;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_first;
  logic         in_ready;
  logic         stall;
  logic [W-1:0] A, B, C;
  logic         op_strobe;
  logic         res_valid;
  logic         sync_err;
`ifdef MAC_LOADER_TRIPLET_CNT_EN
  logic [15:0]  triplet_cnt;
  logic [7:0]   err_cnt;
`endif

  mac_operand_loader #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_ready  (in_ready),
    .stall     (stall),
    .A         (A),
    .B         (B),
    .C         (C),
    .op_strobe (op_strobe),
    .res_valid (res_valid),
    .sync_err  (sync_err)
`ifdef MAC_LOADER_TRIPLET_CNT_EN
    ,
    .triplet_cnt (triplet_cnt),
    .err_cnt     (err_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream multiply-add stage: DATA_OUT <= A*B + C every edge.
  logic [W-1:0] mac_q;
  always_ff @(posedge clk) mac_q <= A * B + C;

  // ---------------- reference model ----------------
  logic [W-1:0] part[$];      // words of the frame currently being collected
  logic [W-1:0] exp_q[$];     // expected results, one per strobed triplet
  logic         exp_ready, exp_strobe, exp_res, exp_err;
  logic [W-1:0] exp_a, exp_b, exp_c, exp_mac;
  logic         seen_ready;
  int unsigned  exp_trip;
  int unsigned  exp_errs;

  int vectors;
  int miscompares;

  task automatic model_reset();
    part.delete();
    exp_strobe = 1'b0;
    exp_res    = 1'b0;
    exp_err    = 1'b0;
    exp_a      = '0;
    exp_b      = '0;
    exp_c      = '0;
    exp_trip   = 0;
    exp_errs   = 0;
  endtask

  // Driver: applies one cycle of stimulus, advances the model, and returns
  // 1 time unit after the edge so outputs can be sampled.
  task automatic step(input logic v, input logic f, input logic [W-1:0] d,
                      input logic s);
    logic acc;
    in_valid = v;
    in_first = f;
    in_data  = d;
    stall    = s;
    #1;
    seen_ready = in_ready;
    exp_ready  = (part.size() == 2) ? !s : 1'b1;
    acc        = v && exp_ready;
    exp_res    = exp_strobe;
    if (exp_strobe) exp_mac = exp_q.pop_front();
    exp_strobe = 1'b0;
    exp_err    = 1'b0;
    if (acc) begin
      if (part.size() == 0) begin
        part.push_back(d);
      end else if (f) begin
        part.delete();
        part.push_back(d);
        exp_err = 1'b1;
        if (exp_errs < 255) exp_errs++;
      end else begin
        part.push_back(d);
        if (part.size() == 3) begin
          exp_a      = part[0];
          exp_b      = part[1];
          exp_c      = part[2];
          exp_strobe = 1'b1;
          exp_q.push_back(W'(part[0] * part[1] + part[2]));
          exp_trip   = (exp_trip + 1) % 65536;
          part.delete();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_data  = '0;
    stall    = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    vectors++;
    if ({in_ready, op_strobe, res_valid, sync_err, A, B, C} !== {4'b1000, {(3*W){1'b0}}}) begin
      $display("FAIL reset: got rdy=%b stb=%b res=%b err=%b A=%h B=%h C=%h, want rdy=1 all else 0",
               in_ready, op_strobe, res_valid, sync_err, A, B, C);
      miscompares++;
    end
    rst_n = 1'b1;
  endtask

  // Runs a stimulus table of {valid, first, data, stall} and checks every cycle.
  task automatic run_table(input string name, input logic [W+2:0] tbl[]);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i][W+2], tbl[i][W+1], tbl[i][W:1], tbl[i][0]);
      vectors++;
      if ({seen_ready, op_strobe, res_valid, sync_err, A, B, C} !==
          {exp_ready, exp_strobe, exp_res, exp_err, exp_a, exp_b, exp_c}) begin
        $display("FAIL %s[%0d]: got rdy=%b stb=%b res=%b err=%b A=%h B=%h C=%h, want rdy=%b stb=%b res=%b err=%b A=%h B=%h C=%h",
                 name, i, seen_ready, op_strobe, res_valid, sync_err, A, B, C,
                 exp_ready, exp_strobe, exp_res, exp_err, exp_a, exp_b, exp_c);
        miscompares++;
      end
      if (exp_res) begin
        vectors++;
        if (mac_q !== exp_mac) begin
          $display("FAIL %s[%0d] data_out: got %h want %h", name, i, mac_q, exp_mac);
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_basic();
    logic [W+2:0] t[];
    t = '{{2'b11, 8'h03, 1'b0}, {2'b10, 8'h05, 1'b0}, {2'b10, 8'h07, 1'b0},
          {2'b00, 8'h00, 1'b0}, {2'b00, 8'h00, 1'b0}};
    run_table("basic", t);
    vectors++;
    if (mac_q !== 8'h16) begin
      $display("FAIL basic_result: got %h want 16", mac_q);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    logic [W+2:0] t[];
    t = '{{2'b11, 8'h02, 1'b0}, {2'b10, 8'h04, 1'b0}, {2'b10, 8'h01, 1'b0},
          {2'b11, 8'h10, 1'b0}, {2'b10, 8'h10, 1'b0}, {2'b10, 8'h00, 1'b0},
          {2'b00, 8'h00, 1'b0}, {2'b00, 8'h00, 1'b0}};
    run_table("back_to_back", t);
    vectors++;
    if (mac_q !== 8'h00) begin
      $display("FAIL wrap_result: got %h want 00", mac_q);
      miscompares++;
    end
  endtask

  task automatic test_resync();
    logic [W+2:0] t[];
    t = '{{2'b11, 8'h11, 1'b0}, {2'b10, 8'h22, 1'b0}, {2'b11, 8'h33, 1'b0},
          {2'b10, 8'h44, 1'b0}, {2'b10, 8'h55, 1'b0}, {2'b00, 8'h00, 1'b0},
          {2'b11, 8'h66, 1'b0}, {2'b11, 8'h77, 1'b0}, {2'b10, 8'h01, 1'b0},
          {2'b10, 8'h02, 1'b0}, {2'b00, 8'h00, 1'b0}};
    run_table("resync", t);
  endtask

  task automatic test_stall();
    logic [W+2:0] t[];
    t = '{{2'b11, 8'h03, 1'b0}, {2'b10, 8'h04, 1'b0}, {2'b10, 8'h09, 1'b1},
          {2'b10, 8'h09, 1'b1}, {2'b11, 8'hAA, 1'b1}, {2'b10, 8'h09, 1'b1},
          {2'b10, 8'h09, 1'b0}, {2'b00, 8'h00, 1'b1}, {2'b00, 8'h00, 1'b0}};
    run_table("stall", t);
  endtask

  task automatic test_reset_mid();
    logic [W+2:0] t[];
    t = '{{2'b11, 8'h21, 1'b0}, {2'b10, 8'h31, 1'b0}};
    run_table("pre_reset", t);
    rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if ({op_strobe, res_valid, sync_err, A, B, C} !== {3'b000, {(3*W){1'b0}}}) begin
      $display("FAIL reset_mid: got stb=%b res=%b err=%b A=%h B=%h C=%h, want all 0",
               op_strobe, res_valid, sync_err, A, B, C);
      miscompares++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    t = '{{2'b10, 8'h41, 1'b0}, {2'b00, 8'h00, 1'b0}, {2'b10, 8'h06, 1'b0},
          {2'b10, 8'h07, 1'b0}, {2'b00, 8'h00, 1'b0}, {2'b00, 8'h00, 1'b0}};
    run_table("post_reset", t);
  endtask

  task automatic test_random();
    logic [W+2:0] t[];
    t = new[600];
    for (int i = 0; i < 600; i++) begin
      t[i] = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
              W'($urandom_range(0, 255)), ($urandom_range(0, 2) == 0)};
    end
    run_table("random", t);
  endtask

`ifdef MAC_LOADER_TRIPLET_CNT_EN
  task automatic test_counters();
    vectors++;
    if ({triplet_cnt, err_cnt} !== {16'(exp_trip), 8'(exp_errs)}) begin
      $display("FAIL counters: got trip=%0d err=%0d want trip=%0d err=%0d",
               triplet_cnt, err_cnt, exp_trip, exp_errs);
      miscompares++;
    end
  endtask
`endif

  // ---------------- main sequence / report ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_mac     = '0;
    seen_ready  = 1'b0;
    exp_ready   = 1'b1;
    model_reset();
    idle();
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_resync();
    test_stall();
    test_reset_mid();
    test_random();
`ifdef MAC_LOADER_TRIPLET_CNT_EN
    test_counters();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
